// File: rtl/store_rmw_pkg.sv
// Shared datapath definitions for the store unit: access sizes and the alignment rule.
package store_rmw_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
        case (size)
            SIZE_H:  is_misaligned = lo[0];
            SIZE_W:  is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_rmw_if.sv
// Request and memory-side bundle of the store unit; mem_be exists only with CONFIG_STORE_BYTE_STROBE_EN.
interface store_rmw_if;
    import store_rmw_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    mem_size_e         req_size;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd_data;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
    logic [3:0]        mem_be;
`endif

    modport master (
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        input  mem_be,
`endif
        output req_valid, req_addr, req_wdata, req_size, mem_rd_data,
        input  req_ready, done, err, mem_addr, mem_re, mem_we, mem_wd_data
    );

    modport slave (
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        output mem_be,
`endif
        input  req_valid, req_addr, req_wdata, req_size, mem_rd_data,
        output req_ready, done, err, mem_addr, mem_re, mem_we, mem_wd_data
    );

endinterface

// File: rtl/store_lane_merge.sv
// Lane logic for sub-word stores: merge into the read word, or (CONFIG_STORE_BYTE_STROBE_EN)
// replicate the data across lanes and produce a byte strobe.
module store_lane_merge
    import store_rmw_pkg::*;
(
    input  mem_size_e         size,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] wd_data,
`ifdef CONFIG_STORE_BYTE_STROBE_EN
    output logic [3:0]        be
`else
    input  logic [DATA_W-1:0] rdata
`endif
);

`ifdef CONFIG_STORE_BYTE_STROBE_EN
    always_comb begin
        wd_data = wdata;
        be      = 4'b1111;
        case (size)
            SIZE_B: begin
                wd_data = {4{wdata[7:0]}};
                be      = 4'b0001 << lane;
            end
            SIZE_H: begin
                wd_data = {2{wdata[15:0]}};
                be      = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        wd_data = rdata;
        case (size)
            SIZE_B: wd_data[8*lane +: 8] = wdata[7:0];
            SIZE_H: begin
                if (lane[1]) wd_data[31:16] = wdata[15:0];
                else         wd_data[15:0]  = wdata[15:0];
            end
            default: wd_data = wdata;
        endcase
    end
`endif

endmodule

// File: rtl/store_rmw.sv
// Store unit: word stores write directly, sub-word stores read-modify-write the containing word.
// CONFIG_STORE_BYTE_STROBE_EN replaces the read phase with a byte-enable write.
module store_rmw
    import store_rmw_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    store_rmw_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_e;

    state_e            state;
    state_e            state_nxt;
    logic              accept;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    mem_size_e         size_q;
    logic [DATA_W-1:0] merged;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
    logic [3:0]        be;
`else
    logic [DATA_W-1:0] rdata_q;
`endif

    assign accept = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0]))
                        state_nxt = ERR;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
                    else
                        state_nxt = WR;
`else
                    else if (bus.req_size == SIZE_W)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
`endif
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = WR;
            WR:      state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are held from acceptance until the next acceptance, keeping mem_addr stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_B;
`ifndef CONFIG_STORE_BYTE_STROBE_EN
            rdata_q <= '0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
            end
`ifndef CONFIG_STORE_BYTE_STROBE_EN
            if (state == WAIT) rdata_q <= bus.mem_rd_data;
`endif
        end
    end

    store_lane_merge u_merge (
        .size    (size_q),
        .lane    (addr_q[1:0]),
        .wdata   (wdata_q),
        .wd_data (merged),
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        .be      (be)
`else
        .rdata   (rdata_q)
`endif
    );

    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.mem_re      = (state == RD);
        bus.mem_we      = (state == WR);
        bus.done        = (state == WR);
        bus.err         = (state == ERR);
        bus.mem_addr    = {addr_q[31:2], 2'b00};
        bus.mem_wd_data = (state == WR) ? merged : '0;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        bus.mem_be      = (state == WR) ? be : 4'b0000;
`endif
    end

endmodule

// File: tb/tb_store_rmw.sv
// Randomized bench for store_rmw against a byte-array memory model; follows CONFIG_STORE_BYTE_STROBE_EN.
module tb_store_rmw;
    import store_rmw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_rmw_if bus ();
    store_rmw dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          collide = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hf);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                               input logic [31:0] wd, input int n);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        for (int k = 0; k < n; k++) b[int'(a % 4) + k] = wd[8*k +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Memory: read data appears only in the cycle after the read strobe.
    always @(negedge clk) begin
        if (rd_pend) bus.mem_rd_data = mem[widx(rd_addr)];
        else         bus.mem_rd_data = $urandom;
        rd_pend = bus.mem_re;
        rd_addr = bus.mem_addr;
        if (bus.mem_re) re_cnt++;
        if (bus.mem_re && bus.mem_we) collide++;
        if (bus.mem_we) begin
            we_cnt++;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) mem[widx(bus.mem_addr)][8*i +: 8] = bus.mem_wd_data[8*i +: 8];
`else
            mem[widx(bus.mem_addr)] = bus.mem_wd_data;
`endif
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
        check_eq({tag, "_re"}, 32'(bus.mem_re), 32'd0);
        check_eq({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check_eq({tag, "_addr"}, bus.mem_addr, 32'd0);
        check_eq({tag, "_wd"}, bus.mem_wd_data, 32'd0);
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        check_eq({tag, "_be"}, 32'(bus.mem_be), 32'd0);
`endif
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        check_eq("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_size  = mem_size_e'(sz);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = mem_size_e'(2'($urandom_range(0, 2)));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int          n = 1 << sz;
        logic        mis = ((a % n) != 0);
        int          exp_lat, exp_re;
        int          lat_we = -1, lat_done = -1, lat_err = -1;
        int          n_re = 0, n_we = 0, n_done = 0, n_errp = 0;
        logic [31:0] old, exp_word, exp_wd, we_data = '0;
        logic        addr_bad = 1'b0;
        logic [3:0]  exp_be = 4'b0000, got_be = 4'b0000;
        logic        be_bad = 1'b0;

        old      = ref_mem[widx(a)];
        exp_word = ref_merge(old, a, wd, n);
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        exp_lat = 1;
        exp_re  = 0;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        exp_be = 4'(((1 << n) - 1) << (a % 4));
`else
        exp_lat = (n == 4) ? 1 : 3;
        exp_re  = (n == 4) ? 0 : 1;
        exp_wd  = exp_word;
`endif
        present(a, wd, sz);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if ((bus.mem_re || bus.mem_we) && bus.mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
            if (bus.mem_re) n_re++;
            if (bus.mem_we) begin
                n_we++;
                lat_we  = cyc;
                we_data = bus.mem_wd_data;
`ifdef CONFIG_STORE_BYTE_STROBE_EN
                got_be = bus.mem_be;
`endif
            end
`ifdef CONFIG_STORE_BYTE_STROBE_EN
            else if (bus.mem_be !== 4'b0000) be_bad = 1'b1;
`endif
            if (bus.done) begin n_done++; lat_done = cyc; end
            if (bus.err)  begin n_errp++; lat_err = cyc; end
            if (bus.done || bus.err) break;
        end
        check_eq("mem_addr_stable", 32'(addr_bad), 32'd0);
        if (mis) begin
            check_eq("err_latency", 32'(lat_err), 32'd1);
            check_eq("err_re_count", 32'(n_re), 32'd0);
            check_eq("err_we_count", 32'(n_we), 32'd0);
            check_eq("err_done_count", 32'(n_done), 32'd0);
        end else begin
            ref_mem[widx(a)] = exp_word;
            check_eq("err_on_aligned", 32'(n_errp), 32'd0);
            check_eq("re_count", 32'(n_re), 32'(exp_re));
            check_eq("we_latency", 32'(lat_we), 32'(exp_lat));
            check_eq("done_latency", 32'(lat_done), 32'(exp_lat));
            check_eq("wd_data", we_data, exp_wd);
`ifdef CONFIG_STORE_BYTE_STROBE_EN
            check_eq("mem_be", 32'(got_be), 32'(exp_be));
`endif
        end
`ifdef CONFIG_STORE_BYTE_STROBE_EN
        check_eq("be_idle_zero", 32'(be_bad), 32'd0);
`endif
        @(negedge clk);
        check_eq("ready_after", 32'(bus.req_ready), 32'd1);
        check_eq("mem_word", mem[widx(a)], ref_mem[widx(a)]);
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[widx(a)]     = v;
        ref_mem[widx(a)] = v;
    endtask

    initial begin
        int we_snap;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_size    = SIZE_B;
        bus.mem_rd_data = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        set_word(32'h100, 32'hdeadbeef);
        do_store(32'h101, 32'h00000055, 2'd0);
        check_eq("sb_0x101_word", mem[0], 32'hdead55ef);

        set_word(32'h100, 32'hdeadbeef);
        do_store(32'h102, 32'hffffc0de, 2'd1);
        check_eq("sh_0x102_word", mem[0], 32'hc0debeef);
        do_store(32'h100, 32'hffffc0de, 2'd1);
        check_eq("sh_0x100_word", mem[0], 32'hc0dec0de);

        do_store(32'h100, 32'hc001c0de, 2'd2);
        check_eq("sw_0x100_word", mem[0], 32'hc001c0de);

        do_store(32'h103, 32'h12345678, 2'd1);
        do_store(32'h102, 32'h9abcdef0, 2'd2);
        check_eq("misaligned_word", mem[0], 32'hc001c0de);

`ifdef CONFIG_STORE_BYTE_STROBE_EN
        do_store(32'h103, 32'h00000055, 2'd0);
        check_eq("sb_0x103_word", mem[0], 32'h5501c0de);
`endif

        // Reset lands mid-store (WAIT in the RMW build, WR in the strobe build).
        set_word(32'h104, 32'h01234567);
        we_snap = we_cnt;
        present(32'h105, 32'h000000aa, 2'd0);
`ifndef CONFIG_STORE_BYTE_STROBE_EN
        @(posedge clk);
`endif
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("abort_no_write", 32'(we_cnt - we_snap), 32'd0);
        check_eq("abort_word", mem[1], 32'h01234567);
        do_store(32'h105, 32'h000000aa, 2'd0);
        check_eq("after_abort_word", mem[1], 32'h0123aa67);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63));
            logic [1:0]  s = 2'($urandom_range(0, 2));
            int          gap = $urandom_range(0, 3);
            if (gap == 3) @(negedge clk);
            do_store(a, $urandom, s);
        end

        for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], ref_mem[i]);
        check_eq("re_we_overlap", 32'(collide), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: the only clock; every flop is rising-edge triggered.
REQ-003 Port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `req_valid`, input, 1 bit: a store request is presented.
REQ-005 Port `req_ready`, output, 1 bit: the unit accepts a request this cycle.
REQ-006 Port `req_addr`, input, 32 bits: byte address of the store.
REQ-007 Port `req_wdata`, input, 32 bits: store data, right-justified.
REQ-008 Port `req_size`, input, `mem_size_e`: SIZE_B, SIZE_H or SIZE_W.
REQ-009 Port `done`, output, 1 bit: one-cycle pulse when the store is committed.
REQ-010 Port `err`, output, 1 bit: one-cycle pulse when a misaligned request is rejected.
REQ-011 Port `mem_addr`, output, 32 bits: word address, equal to `{addr[31:2], 2'b00}`.
REQ-012 Port `mem_re`, output, 1 bit: memory read strobe; read data is valid on the cycle after.
REQ-013 Port `mem_rd_data`, input, 32 bits: memory read data.
REQ-014 Port `mem_we`, output, 1 bit: memory write enable, one cycle per store.
REQ-015 Port `mem_wd_data`, output, 32 bits: full word to be written.

Function
REQ-016 States SHALL be IDLE, RD, WAIT, WR and ERR; `req_ready` SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where `req_valid` and `req_ready` are both 1; `req_addr`, `req_wdata` and `req_size` SHALL be registered on that edge.
REQ-018 Misalignment SHALL be defined as SIZE_H with `addr[0]`=1, or SIZE_W with `addr[1:0]`≠0.
REQ-019 A misaligned request SHALL move IDLE→ERR; ERR SHALL assert `err` for one cycle, make no memory access, then return to IDLE.
REQ-020 An aligned SIZE_W request SHALL move IDLE→WR; WR SHALL drive `mem_we`=1 and `mem_wd_data`=wdata.
REQ-021 An aligned SIZE_B or SIZE_H request SHALL move IDLE→RD→WAIT→WR.
REQ-022 RD SHALL drive `mem_re`=1.
REQ-023 WAIT SHALL capture `mem_rd_data`.
REQ-024 WR SHALL write the captured word with the addressed lanes replaced.
REQ-025 Byte lane merge: lane = `addr[1:0]`, and `wdata[7:0]` SHALL replace bits `[8*lane+7 : 8*lane]`.
REQ-026 Halfword lane merge: `wdata[15:0]` SHALL replace bits `[31:16]` if `addr[1]`=1, else bits `[15:0]`.
REQ-027 Upper bits of `req_wdata` beyond the store size SHALL be ignored.
REQ-028 `done` SHALL be asserted during the WR cycle; the state SHALL then return to IDLE.
REQ-029 Latency from acceptance to `mem_we`: SIZE_W 1 cycle; SIZE_B/SIZE_H 3 cycles.
REQ-030 Back-to-back requests SHALL be allowed, accepted on the first IDLE cycle after WR or ERR.
REQ-031 `mem_re` and `mem_we` SHALL never be asserted in the same cycle.
REQ-032 `mem_addr` SHALL remain stable from RD through WR.

Reset
REQ-033 While `rst`=0, the state SHALL be IDLE and `req_ready`=1.
REQ-034 While `rst`=0, `done`, `err`, `mem_re` and `mem_we` SHALL be 0, and `mem_addr`, `mem_wd_data` and all internal registers SHALL be 0.
REQ-035 Reset asserted in RD, WAIT or WR SHALL abort the store immediately, with no write and no `done`.

Configuration
REQ-036 The feature macro SHALL be `CONFIG_STORE_BYTE_STROBE_EN`.
REQ-037 With the macro defined, an output `mem_be`[3:0] SHALL be added.
REQ-038 With the macro defined, all aligned sizes SHALL go IDLE→WR with no read phase.
REQ-039 With the macro defined, `mem_wd_data` SHALL be the data replicated across lanes: byte ×4, half ×2.
REQ-040 With the macro defined, `mem_be` SHALL be: byte 4'b0001 shifted left by `addr[1:0]`; half 4'b0011 or 4'b1100; word 4'b1111.
REQ-041 With the macro defined, `mem_be` SHALL be 4'b0000 outside WR.
REQ-042 With the macro undefined, the behaviour SHALL be read-modify-write as in REQ-021 to REQ-026, and `mem_be` SHALL be absent.

Structure
REQ-043 `mem_size_e` (SIZE_B=0, SIZE_H=1, SIZE_W=2) SHALL be defined in the shared RISC-V datapath header.
REQ-044 The state enum SHALL be local to the module.
REQ-045 The combinational lane logic (merge, or replicate plus byte strobe) SHALL be one sub-module, `store_lane_merge`.

Verification
REQ-046 Memory word 0x100 = 0xdeadbeef; sb 0x55 at 0x101 → exactly one `mem_re`, then `mem_we` with 0xdead55ef and `done` 3 cycles after acceptance.
REQ-047 Memory word 0x100 = 0xdeadbeef; sh 0xffffc0de at 0x102 → word becomes 0xc0debeef; sh at 0x100 → word becomes 0xc0dec0de.
REQ-048 sw 0xc001c0de at 0x100 → no `mem_re`, `mem_we` 1 cycle after acceptance, word = 0xc001c0de.
REQ-049 sh at 0x103 and sw at 0x102 → `err` pulses once each, `mem_re`=`mem_we`=0 throughout, memory unchanged.
REQ-050 sb accepted, `rst` driven low during WAIT → `mem_we` never asserted, outputs match REQ-034, and the next request completes normally.
REQ-051 With `CONFIG_STORE_BYTE_STROBE_EN` defined: sb 0x55 at 0x103 → `mem_be`=4'b1000, `mem_wd_data`=0x55555555, no `mem_re`, and `done` 1 cycle after acceptance.
